multicycle_control_fsm: RTL

//  Multi-cycle successor to the single-cycle decoder: a Moore FSM sequencing RV32I instructions
//  (FETCH/DECODE/EXEC/MEM/WB) over one shared, handshaked memory port. Full base opcode set:
//  R, I, load, store, branch, JAL, JALR, LUI, AUIPC, FENCE, ECALL/EBREAK. Sits between IR/datapath
//  and memory. Adds illegal-op trap, memory timeout and a retired-instruction counter.

---
 rtl/multicycle_control_fsm_if.sv | 26 ++
 rtl/multicycle_control_fsm.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Shared memory-port bundle between the multicycle control FSM and memory.
//   mem_ready   memory completes the current read/write this cycle
//   MemRead     read request
//   MemWrite    write request
//   IorD        address select: 0 = PC (instruction), 1 = ALU out (data)
//   SaveMethod  store size: 00 = SB, 01 = SH, 10 = SW
//   LoadMethod  load funct3 pass-through (LB/LH/LW/LBU/LHU)
// master: the control FSM; slave: the memory side.
interface multicycle_control_fsm_if;
  logic       mem_ready;
  logic       MemRead;
  logic       MemWrite;
  logic       IorD;
  logic [1:0] SaveMethod;
  logic [2:0] LoadMethod;

  modport master (
    input  mem_ready,
    output MemRead, MemWrite, IorD, SaveMethod, LoadMethod
  );

  modport slave (
    output mem_ready,
    input  MemRead, MemWrite, IorD, SaveMethod, LoadMethod
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for a multicycle RV32I core: FETCH / DECODE / EXEC /
// MEM / WB over a single handshaked memory port, with an illegal-op trap,
// a memory-wait timeout and a saturating retired-instruction counter.
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-low reset
//   Instruction  current IR contents, held stable while an instruction runs
//   bus          memory port (master side): requests out, mem_ready in
//   IRWrite      load IR from memory read data
//   ALUSrcA      00 = rs1, 01 = PC, 10 = zero
//   ALUSrc       0 = rs2, 1 = immediate
//   ALUOp        00 = add, 01 = branch compare, 10 = funct decode
//   Branch       conditional PC update, qualified by the compare in the datapath
//   PCWrite      unconditional PC update
//   PCSrc        00 = PC+4, 01 = PC+imm, 10 = ALU result (JALR)
//   MemtoReg     00 = ALU, 01 = memory, 10 = PC+4
//   RegWrite     register-file write enable
//   state        current state encoding
//   halted       FSM sits in HALT
//   illegal      sticky: undecodable instruction or bad state caused HALT
//   bus_err      sticky: memory wait timeout caused HALT
//   retired      retired-instruction count, saturating
module multicycle_control_fsm #(
  parameter int N       = 32,
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 200,
  parameter int CNT_W   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N-1:0]                 Instruction,
  multicycle_control_fsm_if.master     bus,
  output logic                         IRWrite,
  output logic [1:0]                   ALUSrcA,
  output logic                         ALUSrc,
  output logic [1:0]                   ALUOp,
  output logic                         Branch,
  output logic                         PCWrite,
  output logic [1:0]                   PCSrc,
  output logic [1:0]                   MemtoReg,
  output logic                         RegWrite,
  output logic [2:0]                   state,
  output logic                         halted,
  output logic                         illegal,
  output logic                         bus_err,
  output logic [CNT_W-1:0]             retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    OP_BAD, OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM
  } op_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Last waiting cycle before the timeout fires: TMO_MAX stalled cycles in
  // one access end in HALT unless mem_ready arrives on that very cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

  state_t             state_q, state_d;
  op_t                op;
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [TMO_W-1:0]   wait_cnt_q;
  logic [CNT_W-1:0]   retired_q;
  logic               illegal_q, bus_err_q;
  logic               retire, set_illegal, set_bus_err;
  logic               waiting, tmo_hit;
  logic               unused_instr;

  assign opcode       = Instruction[6:0];
  assign funct3       = Instruction[14:12];
  assign unused_instr = ^{Instruction[N-1:15], Instruction[11:7]};

  // Instruction class; bad funct3 on loads/stores folds into OP_BAD.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through the block infers a latch.
    op = OP_BAD;
    case (opcode)
      OPC_R:      op = OP_R;
      OPC_I:      op = OP_I;
      OPC_LOAD:   op = (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) ? OP_BAD : OP_LOAD;
      OPC_STORE:  op = (funct3 > 3'd2) ? OP_BAD : OP_STORE;
      OPC_BRANCH: op = OP_BRANCH;
      OPC_JAL:    op = OP_JAL;
      OPC_JALR:   op = OP_JALR;
      OPC_LUI:    op = OP_LUI;
      OPC_AUIPC:  op = OP_AUIPC;
      OPC_FENCE:  op = OP_FENCE;
      OPC_SYSTEM: op = OP_SYSTEM;
      default:    op = OP_BAD;
    endcase
  end

  // Memory-wait bookkeeping; the counter is zero whenever an access starts.
  assign waiting = (state_q == S_FETCH || state_q == S_MEM) && !bus.mem_ready;
  assign tmo_hit = waiting && (wait_cnt_q == TMO_LAST);

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d     = S_HALT;
          set_bus_err = 1'b1;
        end
      end
      S_DECODE: begin
        case (op)
          OP_FENCE:  begin state_d = S_FETCH; retire = 1'b1; end
          OP_SYSTEM: begin state_d = S_HALT;  retire = 1'b1; end
          OP_BAD:    begin state_d = S_HALT;  set_illegal = 1'b1; end
          default:   state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_BRANCH:         begin state_d = S_FETCH; retire = 1'b1; end
          default:           state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (op == OP_STORE) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_hit) begin
          state_d     = S_HALT;
          set_bus_err = 1'b1;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: begin
        state_d     = S_HALT;
        set_illegal = 1'b1;
      end
    endcase
  end

  // State register and sticky status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      retired_q  <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      wait_cnt_q <= waiting ? wait_cnt_q + 1'b1 : '0;
      if (retire && (retired_q != {CNT_W{1'b1}})) begin
        retired_q <= retired_q + 1'b1;
      end
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus_err) bus_err_q <= 1'b1;
    end
  end

  // Output decode from state and IR. IRWrite and a store's PCWrite are the
  // only strobes qualified by mem_ready: each must fire exactly once per
  // access however long memory stalls.
  always_comb begin
    IRWrite        = 1'b0;
    bus.IorD       = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.SaveMethod = 2'b00;
    ALUSrcA        = 2'b00;
    ALUSrc         = 1'b0;
    ALUOp          = 2'b00;
    Branch         = 1'b0;
    PCWrite        = 1'b0;
    PCSrc          = 2'b00;
    MemtoReg       = 2'b00;
    RegWrite       = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        IRWrite     = bus.mem_ready;
      end
      S_DECODE: begin
        if (op == OP_FENCE) PCWrite = 1'b1;
      end
      S_EXEC: begin
        case (op)
          OP_R:      ALUOp = 2'b10;
          OP_I:      begin ALUOp = 2'b10; ALUSrc = 1'b1; end
          OP_LUI:    begin ALUSrcA = 2'b10; ALUSrc = 1'b1; end
          OP_AUIPC:  begin ALUSrcA = 2'b01; ALUSrc = 1'b1; end
          OP_LOAD,
          OP_STORE:  ALUSrc = 1'b1;
          OP_BRANCH: begin ALUOp = 2'b01; Branch = 1'b1; PCSrc = 2'b01; end
          OP_JAL:    begin ALUSrcA = 2'b01; ALUSrc = 1'b1; end
          OP_JALR:   ALUSrc = 1'b1;
          default:   ;
        endcase
      end
      S_MEM: begin
        bus.IorD = 1'b1;
        if (op == OP_LOAD) bus.MemRead = 1'b1;
        if (op == OP_STORE) begin
          bus.MemWrite   = 1'b1;
          bus.SaveMethod = funct3[1:0];
          PCWrite        = bus.mem_ready;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        case (op)
          OP_LOAD: MemtoReg = 2'b01;
          OP_JAL:  begin MemtoReg = 2'b10; PCSrc = 2'b01; end
          OP_JALR: begin MemtoReg = 2'b10; PCSrc = 2'b10; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.LoadMethod = funct3;
  assign state          = state_q;
  assign halted         = (state_q == S_HALT);
  assign illegal        = illegal_q;
  assign bus_err        = bus_err_q;
  assign retired        = retired_q;

endmodule
